// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker.
// - state_e : FSM encoding (IDLE / RUN / DONE)
// - DEF_N_IN, DEF_N_OUT : default vector / response widths
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 2;

endpackage

// File: rtl/truth_table_checker_golden_lookup.sv
// tt_golden_lookup: purely combinational golden-table read.
// Ports:
//   i_vec  in  N_IN   vector index into the table
//   o_exp  out N_OUT  expected response, GOLDEN[i_vec*N_OUT +: N_OUT]
module tt_golden_lookup
  import truth_table_checker_pkg::*;
#(
  parameter int                         N_IN   = DEF_N_IN,
  parameter int                         N_OUT  = DEF_N_OUT,
  parameter logic [(2**N_IN)*N_OUT-1:0] GOLDEN = '0
) (
  input  logic [N_IN-1:0]  i_vec,
  output logic [N_OUT-1:0] o_exp
);

  localparam logic [(2**N_IN)*N_OUT-1:0] W_TBL = GOLDEN;

  assign o_exp = W_TBL[int'(i_vec)*N_OUT +: N_OUT];

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: checks (vector, response) pairs against a golden truth
// table, tracks which vectors have been seen and reports a verdict once every
// one of the 2^N_IN vectors has arrived.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               pulse: clear results and (re)start a check
//   vec_valid           vec_in/resp_in hold a pair this cycle
//   vec_in, resp_in     vector applied to the DUT and its response
//   busy                checking in progress
//   err_pulse           one cycle after a mismatching pair
//   err_count           saturating mismatch count
//   first_err           vector of the first mismatch
//   done, pass          coverage complete / complete with no mismatches
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                         N_IN   = DEF_N_IN,
  parameter int                         N_OUT  = DEF_N_OUT,
  parameter logic [(2**N_IN)*N_OUT-1:0] GOLDEN = '0,
  parameter int                         CNT_W  = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [N_IN-1:0]  vec_in,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_err,
  output logic             done,
  output logic             pass
);

  localparam int NV = 2**N_IN;

  state_e           r_state, w_state_nxt;
  logic [NV-1:0]    r_cov;
  logic [NV-1:0]    w_cov_set;
  logic [CNT_W-1:0] r_err_count;
  logic [N_IN-1:0]  r_first_err;
  logic             r_err_pulse;
  logic [N_OUT-1:0] w_exp;
  logic             w_acc;
  logic             w_mis;
  logic             w_cov_full;

  tt_golden_lookup #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .GOLDEN (GOLDEN)
  ) u_lookup (
    .i_vec (vec_in),
    .o_exp (w_exp)
  );

  // start wins over a same-cycle pair, which is dropped.
  assign w_acc      = (r_state == ST_RUN) && vec_valid && !start;
  assign w_mis      = (resp_in != w_exp);
  assign w_cov_set  = r_cov | (NV'(1) << vec_in);
  assign w_cov_full = &w_cov_set;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (start)                   w_state_nxt = ST_RUN;
        else if (w_acc && w_cov_full) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cov       <= '0;
      r_err_count <= '0;
      r_first_err <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_cov       <= '0;
        r_err_count <= '0;
        r_first_err <= '0;
        r_err_pulse <= 1'b0;
      end else if (w_acc) begin
        r_cov       <= w_cov_set;
        r_err_pulse <= w_mis;
        if (w_mis) begin
          if (r_err_count == '0)  r_first_err <= vec_in;
          if (~&r_err_count)      r_err_count <= r_err_count + CNT_W'(1);
        end
      end else begin
        r_err_pulse <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err_count == '0);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign first_err = r_first_err;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  function automatic logic [31:0] mk_golden();
    logic [31:0] g;
    logic [3:0]  v;
    g = '0;
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      g[i*2 +: 2] = {^v, ^v};
    end
    return g;
  endfunction

  localparam logic [31:0] GOLD = mk_golden();

  logic       clk, rst_n, start, vec_valid;
  logic [3:0] vec_in;
  logic [1:0] resp_in;
  logic       busy, err_pulse, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_err;

  truth_table_checker #(.N_IN(4), .N_OUT(2), .GOLDEN(GOLD), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_in(vec_in), .resp_in(resp_in), .busy(busy), .err_pulse(err_pulse),
    .err_count(err_count), .first_err(first_err), .done(done), .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic [4:0] cnt;
    logic [3:0] first;
    logic       done;
    logic       pass;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  // reference model: set of seen vectors plus running tallies
  bit         m_run, m_done, m_pulse;
  int         m_cnt;
  logic [3:0] m_first;
  bit         m_seen[16];

  function automatic logic [1:0] gold(input logic [3:0] v);
    int p;
    p = $countones(v) % 2;
    return (p == 1) ? 2'b11 : 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_first = '0; m_pulse = 0; m_done = 0;
    foreach (m_seen[i]) m_seen[i] = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [3:0] vec,
                            input logic [1:0] resp);
    int n_seen;
    if (s) begin
      model_clear();
      m_run = 1;
    end else if (m_run && v) begin
      m_pulse = (resp != gold(vec));
      if (m_pulse) begin
        if (m_cnt == 0) m_first = vec;
        if (m_cnt < 31) m_cnt++;
      end
      m_seen[vec] = 1;
      n_seen = 0;
      foreach (m_seen[i]) n_seen += m_seen[i];
      if (n_seen == 16) begin m_run = 0; m_done = 1; end
    end else begin
      m_pulse = 0;
    end
  endtask

  // Drive one cycle of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(input bit s, input bit v, input logic [3:0] vec, input logic [1:0] resp);
    exp_t e;
    start = s; vec_valid = v; vec_in = vec; resp_in = resp;
    model_step(s, v, vec, resp);
    e.pulse = m_pulse;
    e.cnt   = 5'(m_cnt);
    e.first = m_first;
    e.done  = m_done;
    e.pass  = m_done && (m_cnt == 0);
    e.busy  = m_run;
    q.push_back(e);
    @(negedge clk);
    start = 0; vec_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 2'b00);
  endtask

  task automatic send(input logic [3:0] v, input logic [1:0] r);
    idle($urandom_range(0, 2));
    step(0, 1, v, r);
  endtask

  // monitor: compare registered outputs one step after each driven cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("err_pulse", {7'd0, err_pulse}, {7'd0, e.pulse});
      chk("err_count", {3'd0, err_count}, {3'd0, e.cnt});
      chk("first_err", {4'd0, first_err}, {4'd0, e.first});
      chk("done",      {7'd0, done},      {7'd0, e.done});
      chk("pass",      {7'd0, pass},      {7'd0, e.pass});
      chk("busy",      {7'd0, busy},      {7'd0, e.busy});
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {7'd0, busy},      8'd0);
    chk({tag, "_pulse"}, {7'd0, err_pulse}, 8'd0);
    chk({tag, "_cnt"},   {3'd0, err_count}, 8'd0);
    chk({tag, "_first"}, {4'd0, first_err}, 8'd0);
    chk({tag, "_done"},  {7'd0, done},      8'd0);
    chk({tag, "_pass"},  {7'd0, pass},      8'd0);
  endtask

  initial begin
    int ord[16];
    int j, t;
    logic [3:0] v;
    rst_n = 0; start = 0; vec_valid = 0; vec_in = 0; resp_in = 0;
    m_run = 0; model_clear();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // vec_valid while IDLE is ignored
    step(0, 1, 4'h3, 2'b01);
    idle(1);

    // T1: all vectors in order, correct
    step(1, 0, 4'h0, 2'b00);
    for (int i = 0; i < 16; i++) begin v = i[3:0]; send(v, gold(v)); end
    idle(2);

    // T2: one wrong response at vector 5
    step(1, 0, 4'h0, 2'b00);
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      send(v, (i == 5) ? 2'b01 : gold(v));
    end
    idle(2);

    // T3: descending with vector 3 duplicated
    step(1, 0, 4'h0, 2'b00);
    for (int i = 15; i >= 0; i--) begin
      v = i[3:0];
      send(v, gold(v));
      if (i == 3) send(v, gold(v));
    end
    idle(2);

    // T4: everything inverted, 32 wrong pairs total -> saturation
    step(1, 0, 4'h0, 2'b00);
    for (int i = 0; i < 15; i++) begin v = i[3:0]; step(0, 1, v, ~gold(v)); end
    for (int i = 0; i < 16; i++) begin
      v = 4'($urandom_range(0, 14));
      step(0, 1, v, ~gold(v));
    end
    step(0, 1, 4'hF, ~gold(4'hF));
    idle(2);

    // T5: async reset mid-check, then a fresh check needs all 16 again
    step(1, 0, 4'h0, 2'b00);
    for (int i = 0; i < 8; i++) begin v = i[3:0]; step(0, 1, v, (i == 2) ? ~gold(v) : gold(v)); end
    #2 rst_n = 0;
    #1 chk_zero("t5_rst");
    m_run = 0; model_clear();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    step(1, 0, 4'h0, 2'b00);
    for (int i = 0; i < 16; i++) begin v = i[3:0]; send(v, gold(v)); end
    idle(1);

    // T6: start with a same-cycle pair, then pairs ignored in DONE
    step(1, 1, 4'h0, 2'b00);
    for (int i = 1; i < 16; i++) begin v = i[3:0]; step(0, 1, v, gold(v)); end
    idle(2);
    step(0, 1, 4'h0, 2'b00);
    step(0, 1, 4'h7, 2'b10);
    step(0, 1, 4'h1, 2'b00);
    idle(2);

    // randomized rounds: shuffled order, random errors, occasional restart
    for (int r = 0; r < 6; r++) begin
      step(1, 0, 4'h0, 2'b00);
      for (int i = 0; i < 16; i++) ord[i] = i;
      for (int i = 15; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
        v = ord[i][3:0];
        if ($urandom_range(0, 3) == 0) send(v, 2'($urandom));
        else send(v, gold(v));
        if ($urandom_range(0, 7) == 0) begin
          v = 4'($urandom);
          send(v, gold(v));
        end
        if (r == 3 && i == 9) step(1, 1, v, 2'b00);
      end
      idle(2);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
